ctrl_sequencer: RTL

Parametrised multi-cycle control sequencer for the simple CPU datapath. Accepts one 23-bit instruction per handshake, steps through per-opcode timing states, and drives one-hot bus tri-state enables, register write enables, ALU control, and PC step/load. It generalises the combinational state/opcode output decoder: register count is configurable, the FSM is internal, fetch uses a valid/ready handshake, and conditional branch and halt are supported.

---
 rtl/ctrl_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction per handshake and steps FETCH/T1..T3.
// Optional halt support is compiled in with `define CTRL_HALT_EN.
module ctrl_sequencer #(
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [22:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              zero_flag,
  output logic [NREG+1:0]   bus_sel,
  output logic [NREG-1:0]   reg_en,
  output logic              a_en,
  output logic              g_en,
  output logic              alu_sub,
  output logic              pc_step,
  output logic              pc_load,
  output logic              done,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_T1    = 3'd1,
    S_T2    = 3'd2,
    S_T3    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_BZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [22:0] r_ir;

  logic [2:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs;
  logic        w_unused_imm;

  assign w_op         = r_ir[22:20];
  assign w_rd         = r_ir[19:16];
  assign w_rs         = r_ir[15:12];
  // The immediate travels to the datapath through the bus, not through this block.
  assign w_unused_imm = ^r_ir[11:0];

  // Register indices outside 0..NREG-1 decode to no enable at all.
  function automatic logic [NREG+1:0] bus_of_reg(input logic [3:0] idx);
    logic [NREG+1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == 4'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [NREG-1:0] wen_of_reg(input logic [3:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == 4'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [NREG+1:0] bus_imm();
    logic [NREG+1:0] v;
    v       = '0;
    v[NREG] = 1'b1;
    return v;
  endfunction

  function automatic logic [NREG+1:0] bus_g();
    logic [NREG+1:0] v;
    v         = '0;
    v[NREG+1] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH && instr_valid) r_ir <= instr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    bus_sel     = '0;
    reg_en      = '0;
    a_en        = 1'b0;
    g_en        = 1'b0;
    alu_sub     = 1'b0;
    pc_step     = 1'b0;
    pc_load     = 1'b0;
    done        = 1'b0;
    halted      = 1'b0;

    case (r_state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          pc_step     = 1'b1;
          w_state_nxt = S_T1;
        end
      end

      S_T1: begin
        w_state_nxt = S_FETCH;
        case (w_op)
          OP_NOP: begin
            done = 1'b1;
          end
          OP_LOAD: begin
            bus_sel = bus_imm();
            reg_en  = wen_of_reg(w_rd);
            done    = 1'b1;
          end
          OP_MOV: begin
            bus_sel = bus_of_reg(w_rs);
            reg_en  = wen_of_reg(w_rd);
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel     = bus_of_reg(w_rd);
            a_en        = 1'b1;
            w_state_nxt = S_T2;
          end
          OP_JMP: begin
            bus_sel = bus_imm();
            pc_load = 1'b1;
            done    = 1'b1;
          end
          OP_BZ: begin
            bus_sel = bus_imm();
            pc_load = zero_flag;
            done    = 1'b1;
          end
          OP_HALT: begin
            done = 1'b1;
`ifdef CTRL_HALT_EN
            w_state_nxt = S_HALT;
`endif
          end
          default: begin
            done = 1'b1;
          end
        endcase
      end

      S_T2: begin
        bus_sel     = bus_of_reg(w_rs);
        g_en        = 1'b1;
        alu_sub     = w_op[2];
        w_state_nxt = S_T3;
      end

      S_T3: begin
        bus_sel     = bus_g();
        reg_en      = wen_of_reg(w_rd);
        done        = 1'b1;
        w_state_nxt = S_FETCH;
      end

      S_HALT: begin
`ifdef CTRL_HALT_EN
        halted      = 1'b1;
        w_state_nxt = S_HALT;
`else
        w_state_nxt = S_FETCH;
`endif
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

endmodule
